// File: rtl/store_checker.sv
// Store checker: compares a monitored store stream against a table of expected
// {address, data} pairs and reports pass, fail with a cause, or timeout.
module store_checker #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024,
    parameter int STRICT  = 1,
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [CW-1:0]     cfg_count,
    input  logic              start,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [2:0]        fail_code,
    output logic [CW-1:0]     match_cnt,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     count_r;
    logic [TW-1:0]     cyc_r;
    logic [ADDR_W-1:0] tbl_addr [DEPTH];
    logic [DATA_W-1:0] tbl_data [DEPTH];

    logic [ADDR_W-1:0] exp_addr_s;
    logic [DATA_W-1:0] exp_data_s;
    logic              addr_hit_s;
    logic              match_s;
    logic              last_s;
    logic              tmo_s;
    logic              cfg_ok_s;

    // Expected-store table; deliberately not reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (state_r == IDLE && cfg_we) begin
            tbl_addr[cfg_idx] <= cfg_addr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    // Compare the current store against the entry selected by match_cnt, which doubles as the table pointer.
    always_comb begin
        exp_addr_s = tbl_addr[match_cnt[IW-1:0]];
        exp_data_s = tbl_data[match_cnt[IW-1:0]];
        addr_hit_s = memwrite && (dataadr == exp_addr_s);
        match_s    = addr_hit_s && (writedata == exp_data_s);
        last_s     = ((match_cnt + CW'(1)) == count_r);
        tmo_s      = (cyc_r == TW'(TIMEOUT - 1));
        cfg_ok_s   = (cfg_count != CW'(0)) && (cfg_count <= CW'(DEPTH));
    end

    // Checker FSM with registered status outputs; a final match beats a coincident timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            count_r   <= CW'(0);
            cyc_r     <= TW'(0);
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 3'd0;
            match_cnt <= CW'(0);
            err_addr  <= ADDR_W'(0);
            err_data  <= DATA_W'(0);
        end else if (clear) begin
            state_r   <= IDLE;
            count_r   <= CW'(0);
            cyc_r     <= TW'(0);
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= 3'd0;
            match_cnt <= CW'(0);
            err_addr  <= ADDR_W'(0);
            err_data  <= DATA_W'(0);
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok_s) begin
                            state_r   <= RUN;
                            count_r   <= cfg_count;
                            cyc_r     <= TW'(0);
                            match_cnt <= CW'(0);
                            busy      <= 1'b1;
                        end else begin
                            state_r   <= FAIL;
                            done      <= 1'b1;
                            fail      <= 1'b1;
                            fail_code <= 3'd4;
                        end
                    end
                end
                RUN: begin
                    cyc_r <= cyc_r + TW'(1);
                    if (match_s) begin
                        match_cnt <= match_cnt + CW'(1);
                        if (last_s) begin
                            state_r <= PASS;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= 1'b1;
                        end else if (tmo_s) begin
                            state_r   <= FAIL;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            fail      <= 1'b1;
                            fail_code <= 3'd3;
                        end
                    end else if (addr_hit_s) begin
                        state_r   <= FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= 3'd2;
                        err_addr  <= dataadr;
                        err_data  <= writedata;
                    end else if (memwrite && (STRICT != 0)) begin
                        state_r   <= FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= 3'd1;
                        err_addr  <= dataadr;
                        err_data  <= writedata;
                    end else if (tmo_s) begin
                        state_r   <= FAIL;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        fail_code <= 3'd3;
                    end
                end
                PASS: state_r <= PASS;
                FAIL: state_r <= FAIL;
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    fail      <= 1'b0;
                    fail_code <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: a strict and a non-strict instance share stimulus and
// are compared against a behavioural model of the expected-store rules.
module tb_store_checker;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } st_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_idx = 3'd0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_data = '0;
    logic [3:0]    cfg_count = 4'd0;
    logic          start = 1'b0;
    logic          memwrite = 1'b0;
    logic [AW-1:0] dataadr = '0;
    logic [DW-1:0] writedata = '0;

    logic          busy [2];
    logic          done [2];
    logic          pass [2];
    logic          fail [2];
    logic [2:0]    fail_code [2];
    logic [3:0]    match_cnt [2];
    logic [AW-1:0] err_addr [2];
    logic [DW-1:0] err_data [2];

    logic [AW-1:0] m_addr [DEPTH];
    logic [DW-1:0] m_data [DEPTH];

    int checks = 0;
    int errors = 0;

    store_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TMO), .STRICT(1)) dut_strict (
        .clk(clk), .reset(reset), .clear(clear), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
        .fail_code(fail_code[0]), .match_cnt(match_cnt[0]),
        .err_addr(err_addr[0]), .err_data(err_data[0]));

    store_checker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .TIMEOUT(TMO), .STRICT(0)) dut_loose (
        .clk(clk), .reset(reset), .clear(clear), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
        .fail_code(fail_code[1]), .match_cnt(match_cnt[1]),
        .err_addr(err_addr[1]), .err_data(err_data[1]));

    always #5 clk = ~clk;

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Writes one table entry (after returning both checkers to IDLE) and mirrors it.
    task automatic load(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
        do_clear();
        cfg_we   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_addr = a;
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        m_addr[idx] = a;
        m_data[idx] = d;
    endtask

    // Reference: walk the stores edge by edge; edg = edge after start where done rises.
    task automatic model(input bit strict, input int cnt, input st_t seq[$],
                         output int code, output int mc, output int edg,
                         output logic [AW-1:0] ea, output logic [DW-1:0] ed);
        st_t s;
        code = 0; mc = 0; edg = -1; ea = '0; ed = '0;
        if (cnt < 1 || cnt > DEPTH) begin
            code = 4; edg = 0;
            return;
        end
        for (int k = 1; k <= TMO; k++) begin
            s = (k <= seq.size()) ? seq[k-1] : '0;
            if (s.v) begin
                if (s.a == m_addr[mc]) begin
                    if (s.d == m_data[mc]) begin
                        mc++;
                        if (mc == cnt) begin
                            edg = k;
                            return;
                        end
                    end else begin
                        code = 2; ea = s.a; ed = s.d; edg = k;
                        return;
                    end
                end else if (strict) begin
                    code = 1; ea = s.a; ed = s.d; edg = k;
                    return;
                end
            end
            if (k == TMO) begin
                code = 3; edg = k;
                return;
            end
        end
    endtask

    // Starts a run, plays seq one store per edge, then checks both instances against the model.
    task automatic run_seq(input string name, input int cnt, input st_t seq[$], input bit poke);
        int seen [2];
        int code, mc, edg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        seen[0] = -1;
        seen[1] = -1;
        do_clear();
        cfg_count = 4'(cnt);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int d = 0; d < 2; d++) if (done[d]) seen[d] = 0;
        for (int k = 1; k <= TMO + 4; k++) begin
            if (k <= seq.size()) begin
                memwrite  = seq[k-1].v;
                dataadr   = seq[k-1].a;
                writedata = seq[k-1].d;
            end else begin
                memwrite = 1'b0;
            end
            if (poke) begin
                cfg_we   = 1'b1;
                cfg_idx  = 3'($urandom_range(0, 7));
                cfg_addr = $urandom;
                cfg_data = $urandom;
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (done[d] && seen[d] < 0) seen[d] = k;
        end
        memwrite = 1'b0;
        cfg_we = 1'b0;
        for (int d = 0; d < 2; d++) begin
            model(d == 0, cnt, seq, code, mc, edg, ea, ed);
            checks++;
            if (seen[d] != edg) begin
                errors++;
                $display("FAIL %s/dut%0d done_edge got %0d want %0d", name, d, seen[d], edg);
            end
            checks++;
            if ({busy[d], done[d], pass[d], fail[d]} !== {1'b0, 1'b1, code == 0, code != 0}) begin
                errors++;
                $display("FAIL %s/dut%0d busy_done_pass_fail got %b%b%b%b want 01%b%b", name, d,
                         busy[d], done[d], pass[d], fail[d], code == 0, code != 0);
            end
            checks++;
            if (fail_code[d] !== 3'(code)) begin
                errors++;
                $display("FAIL %s/dut%0d fail_code got %0d want %0d", name, d, fail_code[d], code);
            end
            checks++;
            if (match_cnt[d] !== 4'(mc)) begin
                errors++;
                $display("FAIL %s/dut%0d match_cnt got %0d want %0d", name, d, match_cnt[d], mc);
            end
            checks++;
            if (err_addr[d] !== ea || err_data[d] !== ed) begin
                errors++;
                $display("FAIL %s/dut%0d err got %h/%h want %h/%h", name, d, err_addr[d], err_data[d], ea, ed);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], pass[d], fail[d], fail_code[d], match_cnt[d], err_addr[d], err_data[d]} !== '0) begin
                errors++;
                $display("FAIL reset/dut%0d outputs got %b%b%b%b code %0d cnt %0d err %h/%h want all 0", d,
                         busy[d], done[d], pass[d], fail[d], fail_code[d], match_cnt[d], err_addr[d], err_data[d]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        st_t q[$];
        load(0, 32'd80, 32'd7);
        q = {};
        q.push_back('{1'b1, 32'd80, 32'd7});
        run_seq("basic", 1, q, 1'b0);
    endtask

    task automatic test_strict_addr();
        st_t q[$];
        q = {};
        q.push_back('{1'b1, 32'd84, 32'd7});
        run_seq("addr_mismatch", 1, q, 1'b0);
    endtask

    task automatic test_loose_skip();
        st_t q[$];
        load(1, 32'd84, 32'd9);
        q = {};
        q.push_back('{1'b1, 32'd60, 32'd1});
        q.push_back('{1'b1, 32'd80, 32'd7});
        q.push_back('{1'b1, 32'd84, 32'd9});
        run_seq("loose_pass", 2, q, 1'b0);
        q[2] = '{1'b1, 32'd84, 32'd5};
        run_seq("data_mismatch", 2, q, 1'b0);
    endtask

    task automatic test_timeout();
        st_t q[$];
        q = {};
        run_seq("timeout", 1, q, 1'b0);
        for (int i = 0; i < TMO - 1; i++) q.push_back('0);
        q.push_back('{1'b1, 32'd80, 32'd7});
        run_seq("timeout_tie", 1, q, 1'b0);
    endtask

    task automatic test_config();
        st_t q[$];
        q = {};
        q.push_back('{1'b1, 32'd80, 32'd7});
        run_seq("count0", 0, q, 1'b0);
        run_seq("count9", 9, q, 1'b0);
        run_seq("cfg_locked", 2, q, 1'b1);
    endtask

    task automatic test_reset_midrun();
        st_t q[$];
        load(0, 32'd80, 32'd7);
        load(1, 32'd84, 32'd9);
        do_clear();
        cfg_count = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        memwrite = 1'b1; dataadr = 32'd80; writedata = 32'd7;
        @(negedge clk);
        memwrite = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy[d] !== 1'b1 || match_cnt[d] !== 4'd1) begin
                errors++;
                $display("FAIL midrun/dut%0d busy,cnt got %b,%0d want 1,1", d, busy[d], match_cnt[d]);
            end
        end
        #2 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], match_cnt[d]} !== '0) begin
                errors++;
                $display("FAIL async_reset/dut%0d busy,done,cnt got %b,%b,%0d want 0,0,0", d, busy[d], done[d], match_cnt[d]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        q = {};
        q.push_back('{1'b1, 32'd80, 32'd7});
        q.push_back('{1'b1, 32'd84, 32'd9});
        run_seq("after_reset", 2, q, 1'b0);
    endtask

    task automatic test_clear();
        clear = 1'b1;
        start = 1'b1;
        cfg_count = 4'd1;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], pass[d], fail[d], fail_code[d], match_cnt[d], err_addr[d], err_data[d]} !== '0) begin
                errors++;
                $display("FAIL clear/dut%0d outputs got %b%b%b%b code %0d cnt %0d want all 0", d,
                         busy[d], done[d], pass[d], fail[d], fail_code[d], match_cnt[d]);
            end
        end
    endtask

    task automatic test_random();
        st_t q[$];
        st_t s;
        int cnt, gm, len, r, idx;
        for (int it = 0; it < 60; it++) begin
            for (int e = 0; e < DEPTH; e++)
                load(e, 32'h40 + 32'($urandom_range(0, 3)) * 32'd4, 32'($urandom_range(0, 3)));
            cnt = ($urandom_range(0, 7) == 0) ? 9 * int'($urandom_range(0, 1)) : int'($urandom_range(1, DEPTH));
            len = $urandom_range(0, TMO + 4);
            gm = 0;
            q = {};
            for (int j = 0; j < len; j++) begin
                r = $urandom_range(0, 11);
                idx = (gm < DEPTH) ? gm : 0;
                if (r <= 6) begin
                    s = '{1'b1, m_addr[idx], m_data[idx]};
                    gm++;
                end else if (r <= 8) begin
                    s = '0;
                end else if (r == 9) begin
                    s = '{1'b1, m_addr[idx] ^ 32'h100, m_data[idx]};
                end else if (r == 10) begin
                    s = '{1'b1, m_addr[idx], m_data[idx] ^ 32'h1};
                end else begin
                    s = '{1'b1, 32'h40 + 32'($urandom_range(0, 3)) * 32'd4, 32'($urandom_range(0, 3))};
                end
                q.push_back(s);
            end
            run_seq("random", cnt, q, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_strict_addr();
        test_loose_skip();
        test_timeout();
        test_config();
        test_reset_midrun();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_checker.md
STORE_CHECKER -- requirements
Module: store_checker

Interface
REQ-001 Parameter DATA_W, default 32, width of the store data bus.
REQ-002 Parameter ADDR_W, default 32, width of the store address bus.
REQ-003 Parameter DEPTH, default 8, number of entries in the expected-store table; DEPTH SHALL be at least 1.
REQ-004 Parameter TIMEOUT, default 1024, run-cycle limit before failure; TIMEOUT SHALL be at least 1.
REQ-005 Parameter STRICT, default 1: 1 means every store is checked in order; 0 means stores to non-expected addresses are ignored.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 clear  in  1  synchronous return to IDLE.
REQ-009 cfg_we  in  1  table write strobe.
REQ-010 cfg_idx  in  $clog2(DEPTH)  table entry index.
REQ-011 cfg_addr  in  ADDR_W  expected store address.
REQ-012 cfg_data  in  DATA_W  expected store data.
REQ-013 cfg_count  in  $clog2(DEPTH+1)  number of expected stores, sampled on start.
REQ-014 start  in  1  begin checking.
REQ-015 memwrite  in  1  monitored store strobe.
REQ-016 dataadr  in  ADDR_W  monitored store address.
REQ-017 writedata  in  DATA_W  monitored store data.
REQ-018 busy  out  1  high in RUN.
REQ-019 done  out  1  high in PASS or FAIL.
REQ-020 pass  out  1  high in PASS.
REQ-021 fail  out  1  high in FAIL.
REQ-022 fail_code  out  3  0 none, 1 address mismatch, 2 data mismatch, 3 timeout, 4 configuration error.
REQ-023 match_cnt  out  $clog2(DEPTH+1)  number of expected stores matched.
REQ-024 err_addr, err_data  out  ADDR_W, DATA_W  captured offending store.

Function
REQ-025 The FSM SHALL have exactly four states: IDLE, RUN, PASS, FAIL; all inputs are sampled on the rising edge of clk.
REQ-026 In IDLE, when cfg_we=1, entry[cfg_idx] SHALL be written with {cfg_addr, cfg_data}; cfg_we SHALL be ignored in every other state.
REQ-027 In IDLE, start=1 with cfg_count in 1..DEPTH SHALL do all of the following on that edge: latch cfg_count, clear the pointer, match_cnt and the cycle counter, and enter RUN.
REQ-028 In IDLE, start=1 with cfg_count=0 or cfg_count>DEPTH SHALL enter FAIL with fail_code=4.
REQ-029 In RUN, the cycle counter SHALL increment every cycle.
REQ-030 In RUN, a store (memwrite=1) whose address and data equal entry[ptr] SHALL increment ptr and match_cnt; if it is the last expected store, the FSM SHALL enter PASS on the same edge.
REQ-031 In RUN with STRICT=1, a store with dataadr not equal to the expected address SHALL enter FAIL with code 1.
REQ-032 In RUN with STRICT=0, a store with dataadr not equal to the expected address SHALL be ignored.
REQ-033 In RUN, a store with the expected address but different data SHALL enter FAIL with code 2 in both modes.
REQ-034 On entering FAIL with code 1 or 2, err_addr and err_data SHALL capture dataadr and writedata; they SHALL hold otherwise.
REQ-035 In RUN, when the cycle counter reaches TIMEOUT-1 with no final match, the FSM SHALL enter FAIL with code 3 on that edge.
REQ-036 If a final match and the timeout occur on the same edge, PASS SHALL win.
REQ-037 Stores SHALL be ignored outside RUN, and start SHALL be ignored outside IDLE.
REQ-038 PASS and FAIL SHALL hold (sticky) until clear or reset.
REQ-039 clear=1 SHALL return the FSM to IDLE from any state and zero every output; clear SHALL take priority over start.
REQ-040 Outputs SHALL be registered and decoded from state: busy=RUN, done=PASS|FAIL.

Reset
REQ-041 reset=0 SHALL immediately, including mid-RUN, force IDLE and set busy, done, pass, fail, fail_code, match_cnt, err_addr, err_data and the latched count to 0.
REQ-042 Table entries SHALL NOT be reset; their contents are undefined until written.

Verification
REQ-043 Load entry0=(80,7), then start with count=1; a store (80,7) SHALL give pass=1, done=1 and match_cnt=1 on the next cycle.
REQ-044 STRICT=1 with entry0=(80,7): a store (84,7) SHALL give fail=1, fail_code=1, err_addr=84.
REQ-045 STRICT=0 with entries (80,7) and (84,9): the stores (60,1), (80,7), (84,9) SHALL give pass=1 and match_cnt=2; a store (84,5) instead of (84,9) SHALL give fail_code=2 and err_data=5.
REQ-046 TIMEOUT=16, count=1, no stores: fail_code=3 SHALL assert on exactly the 16th edge after start; with a matching store on that same edge, pass=1 SHALL assert instead.
REQ-047 start with count=0 SHALL give fail_code=4; asserting reset=0 mid-RUN and then a fresh load and run SHALL pass; clear from PASS SHALL return all outputs to 0.
